// File: rtl/mips_cpu_fetch.sv
// Instruction fetch unit: Avalon-MM read master between the PC stage and decode.
// Optional bus-timeout watchdog with sticky error and HALT state: define MIPS_CPU_FETCH_TIMEOUT_EN.
module mips_cpu_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        active,
    input  logic        flush,
    input  logic        fetch_ready,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        pc_stall,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        discard_q, discard_d;
    logic        armed_q;
    logic [31:0] pc_aligned;

    assign pc_aligned = pc_in & 32'hFFFF_FFFC;

`ifdef MIPS_CPU_FETCH_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    // armed_q holds off the first fetch so no request can be issued on the first edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= 32'd0;
            instr_q   <= 32'd0;
            valid_q   <= 1'b0;
            discard_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            discard_q <= discard_d;
            armed_q   <= 1'b1;
        end
    end

`ifdef MIPS_CPU_FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        discard_d = discard_q;
`ifdef MIPS_CPU_FETCH_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (active && armed_q) begin
                    addr_d  = pc_aligned;
                    state_d = READ;
                end
            end
            READ: begin
                if (!avm_waitrequest) begin
`ifdef MIPS_CPU_FETCH_TIMEOUT_EN
                    cnt_d = 16'd0;
`endif
                    // A flush seen at any point during the transfer drops the returning word.
                    if (discard_q || flush) begin
                        discard_d = 1'b0;
                        valid_d   = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        instr_d = avm_readdata;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else begin
                    if (flush) begin
                        discard_d = 1'b1;
                    end
`ifdef MIPS_CPU_FETCH_TIMEOUT_EN
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == TIMEOUT_LIM) begin
                        err_d     = 1'b1;
                        discard_d = 1'b0;
                        valid_d   = 1'b0;
                        state_d   = HALT;
                    end
`endif
                end
            end
            HOLD: begin
                if (flush) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (fetch_ready) begin
                    valid_d = 1'b0;
                    if (active) begin
                        addr_d  = pc_aligned;
                        state_d = READ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign avm_read    = (state_q == READ);
    assign avm_address = addr_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc_stall    = (state_q == HALT) ||
                         (active && !((state_q == HOLD) && fetch_ready));

`ifdef MIPS_CPU_FETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Directed bench for mips_cpu_fetch; timeout scenario runs only when MIPS_CPU_FETCH_TIMEOUT_EN is defined.
module tb_mips_cpu_fetch;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic        active = 1'b0;
    logic        flush = 1'b0;
    logic        fetch_ready = 1'b0;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        pc_stall;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    mips_cpu_fetch #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .rst(rst),
        .pc_in(pc_in),
        .active(active),
        .flush(flush),
        .fetch_ready(fetch_ready),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .instr_out(instr_out),
        .instr_valid(instr_valid),
        .pc_stall(pc_stall),
        .fetch_err(fetch_err)
    );

    always #5 clk = clk_en ? ~clk : clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    initial begin
        // Reset state
        step();
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_addr", avm_address, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_stall", 32'(pc_stall), 32'd0);
        step();

        // Release reset with active already high: no request on the first edge
        rst = 1'b1;
        active = 1'b1;
        pc_in = 32'hBFC00000;
        avm_readdata = 32'h24020005;
        step();
        chk("first_edge_noread", 32'(avm_read), 32'd0);
        chk("idle_stall", 32'(pc_stall), 32'd1);

        // Zero-wait read
        step();
        chk("zw_read", 32'(avm_read), 32'd1);
        chk("zw_addr", avm_address, 32'hBFC00000);
        chk("zw_valid_lo", 32'(instr_valid), 32'd0);
        step();
        chk("zw_valid", 32'(instr_valid), 32'd1);
        chk("zw_instr", instr_out, 32'h24020005);
        chk("zw_read_done", 32'(avm_read), 32'd0);
        chk("hold_stall", 32'(pc_stall), 32'd1);

        // HOLD without fetch_ready keeps the word
        avm_readdata = 32'h0BADF00D;
        step();
        chk("hold_keep_valid", 32'(instr_valid), 32'd1);
        chk("hold_keep_instr", instr_out, 32'h24020005);

        // Back-to-back fetch
        fetch_ready = 1'b1;
        pc_in = 32'hBFC00004;
        #1;
        chk("b2b_stall_lo", 32'(pc_stall), 32'd0);
        step();
        chk("b2b_read", 32'(avm_read), 32'd1);
        chk("b2b_addr", avm_address, 32'hBFC00004);
        chk("b2b_valid_lo", 32'(instr_valid), 32'd0);
        chk("b2b_stall_hi", 32'(pc_stall), 32'd1);

        // Three wait states on this read
        fetch_ready = 1'b0;
        avm_waitrequest = 1'b1;
        avm_readdata = 32'h8C430010;
        pc_in = 32'h00000100;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_read", 32'(avm_read), 32'd1);
            chk("ws_addr", avm_address, 32'hBFC00004);
            chk("ws_valid_lo", 32'(instr_valid), 32'd0);
        end
        avm_waitrequest = 1'b0;
        step();
        chk("ws_valid", 32'(instr_valid), 32'd1);
        chk("ws_instr", instr_out, 32'h8C430010);

        // HOLD with fetch_ready and active low goes idle
        active = 1'b0;
        fetch_ready = 1'b1;
        #1;
        chk("inactive_stall", 32'(pc_stall), 32'd0);
        step();
        chk("inactive_valid", 32'(instr_valid), 32'd0);
        chk("inactive_read", 32'(avm_read), 32'd0);
        fetch_ready = 1'b0;

        // Flush during second READ cycle, unaligned PC
        active = 1'b1;
        pc_in = 32'hBFC00013;
        step();
        chk("fl_addr_align", avm_address, 32'hBFC00010);
        avm_waitrequest = 1'b1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        active = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'hDEADBEEF;
        chk("fl_not_aborted", 32'(avm_read), 32'd1);
        step();
        chk("fl_valid", 32'(instr_valid), 32'd0);
        chk("fl_idle_read", 32'(avm_read), 32'd0);
        step();
        chk("fl_idle_valid", 32'(instr_valid), 32'd0);
        chk("fl_idle_read2", 32'(avm_read), 32'd0);

        // Flush in HOLD beats fetch_ready
        active = 1'b1;
        pc_in = 32'hBFC00020;
        avm_readdata = 32'h11111111;
        step();
        step();
        chk("fh_valid_hi", 32'(instr_valid), 32'd1);
        chk("fh_instr", instr_out, 32'h11111111);
        flush = 1'b1;
        fetch_ready = 1'b1;
        step();
        chk("fh_valid", 32'(instr_valid), 32'd0);
        chk("fh_read", 32'(avm_read), 32'd0);
        fetch_ready = 1'b0;

        // Flush in IDLE ignored, then flush on completion edge
        pc_in = 32'hBFC00030;
        step();
        chk("fi_read", 32'(avm_read), 32'd1);
        chk("fi_addr", avm_address, 32'hBFC00030);
        step();
        chk("fc_valid", 32'(instr_valid), 32'd0);
        chk("fc_read", 32'(avm_read), 32'd0);
        flush = 1'b0;
        active = 1'b0;
        step();

        // Async reset mid-READ with the clock stopped
        active = 1'b1;
        pc_in = 32'hBFC00040;
        avm_waitrequest = 1'b1;
        step();
        chk("ar_read_hi", 32'(avm_read), 32'd1);
        clk_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_read", 32'(avm_read), 32'd0);
        chk("ar_valid", 32'(instr_valid), 32'd0);
        chk("ar_addr", avm_address, 32'd0);
        #20;
        chk("ar_read_held", 32'(avm_read), 32'd0);
        clk_en = 1'b1;
        step();
        rst = 1'b1;

`ifdef MIPS_CPU_FETCH_TIMEOUT_EN
        // Watchdog: 8 stalled READ cycles trip the error
        step();
        step();
        chk("to_read", 32'(avm_read), 32'd1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_err_lo", 32'(fetch_err), 32'd0);
            chk("to_read_hi", 32'(avm_read), 32'd1);
        end
        step();
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_read_drop", 32'(avm_read), 32'd0);
        chk("to_stall", 32'(pc_stall), 32'd1);
        avm_waitrequest = 1'b0;
        active = 1'b0;
        step();
        step();
        chk("halt_err", 32'(fetch_err), 32'd1);
        chk("halt_read", 32'(avm_read), 32'd0);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_stall", 32'(pc_stall), 32'd1);
        rst = 1'b0;
        #1;
        chk("halt_rst_err", 32'(fetch_err), 32'd0);
        chk("halt_rst_stall", 32'(pc_stall), 32'd0);
`else
        // Without the watchdog a long stall never errors
        step();
        step();
        chk("nt_read", 32'(avm_read), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        chk("nt_read_hi", 32'(avm_read), 32'd1);
        chk("nt_err", 32'(fetch_err), 32'd0);
        chk("nt_addr", avm_address, 32'hBFC00040);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_fetch.md
MIPS_CPU_FETCH -- requirements
Module: mips_cpu_fetch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of consecutive stalled READ cycles before a fetch error is raised (valid range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port pc_in  input  32  fetch address from the PC stage.
REQ-005 SHALL have port active  input  1  CPU running flag from the PC stage.
REQ-006 SHALL have port flush  input  1  discard any pending or held instruction (branch/jump redirect).
REQ-007 SHALL have port fetch_ready  input  1  downstream decode accepts instr_out this cycle.
REQ-008 SHALL have port avm_address  output  32  memory read address, word aligned.
REQ-009 SHALL have port avm_read  output  1  memory read request.
REQ-010 SHALL have port avm_waitrequest  input  1  memory not ready; the request is held while high.
REQ-011 SHALL have port avm_readdata  input  32  read data, valid when avm_read=1 and avm_waitrequest=0.
REQ-012 SHALL have port instr_out  output  32  fetched instruction word.
REQ-013 SHALL have port instr_valid  output  1  instr_out holds a valid instruction.
REQ-014 SHALL have port pc_stall  output  1  PC stage must not advance.
REQ-015 SHALL have port fetch_err  output  1  sticky bus-timeout error.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, READ, HOLD, HALT.
REQ-017 IDLE: when active=1, SHALL register avm_address={pc_in[31:2],2'b00} and enter READ next cycle; otherwise it SHALL stay in IDLE.
REQ-018 READ: SHALL drive avm_read=1 and hold avm_address constant until a cycle in which avm_waitrequest=0.
REQ-019 READ completion without a discard: SHALL register avm_readdata into instr_out, set instr_valid=1, and enter HOLD on the next edge.
REQ-020 Minimum latency SHALL be 2 cycles from active being sampled in IDLE to instr_valid=1, with zero wait states.
REQ-021 HOLD with fetch_ready=1 and active=1: SHALL sample the new pc_in and return to READ with avm_read=1 on the next cycle, with no IDLE bubble.
REQ-022 HOLD with fetch_ready=1 and active=0: SHALL clear instr_valid and enter IDLE.
REQ-023 HOLD with fetch_ready=0: SHALL keep instr_out and instr_valid unchanged.
REQ-024 pc_stall SHALL equal NOT(state==HOLD AND fetch_ready=1) while active=1, and SHALL be 0 while active=0.
REQ-025 flush in READ: the bus read SHALL NOT be aborted; a discard flag SHALL be set, the returning data SHALL be dropped (instr_valid stays 0), and the FSM SHALL enter IDLE.
REQ-026 flush in the same cycle as READ completion: the data SHALL be dropped and the FSM SHALL enter IDLE.
REQ-027 flush in HOLD SHALL take priority over fetch_ready: instr_valid SHALL clear next cycle and the FSM SHALL enter IDLE.
REQ-028 flush in IDLE SHALL have no effect.
REQ-029 instr_valid SHALL never be 1 outside HOLD.

Reset
REQ-030 rst=0 SHALL immediately force the FSM to IDLE, avm_read=0, avm_address=0, instr_out=0, instr_valid=0, fetch_err=0, the discard flag to 0 and the timeout counter to 0, regardless of the clock.
REQ-031 Reset asserted mid-READ SHALL drop the request at once, with no completion.
REQ-032 After rst deasserts, the first avm_read SHALL NOT occur before the second rising edge.

Configuration
REQ-033 With macro MIPS_CPU_FETCH_TIMEOUT_EN defined: a 16-bit counter SHALL increment on each READ cycle with avm_waitrequest=1 and clear on READ completion.
REQ-034 With the macro defined, reaching TIMEOUT_CYCLES SHALL set fetch_err=1 (sticky), drop avm_read, and enter HALT.
REQ-035 With the macro defined, HALT SHALL hold pc_stall=1 and instr_valid=0; only reset SHALL exit HALT.
REQ-036 Without the macro: there SHALL be no counter and no HALT entry, READ SHALL wait indefinitely, and fetch_err SHALL be tied to 0.

Verification
REQ-037 Zero-wait read: active=1, pc_in=0xBFC00000, waitrequest=0, readdata=0x24020005 -> avm_address=0xBFC00000 and instr_out=0x24020005 with instr_valid=1 two cycles after active is sampled.
REQ-038 Wait states: waitrequest high for 3 cycles -> avm_read and avm_address stable for 4 cycles, then instr_valid=1 with the correct data.
REQ-039 Back-to-back: fetch_ready=1 in HOLD, pc_in=0xBFC00004 -> avm_read=1 on the next cycle at 0xBFC00004, pc_stall=0 for exactly that one cycle.
REQ-040 Flush: flush=1 in the second READ cycle, then completion with readdata=0xDEADBEEF -> instr_valid stays 0 and the FSM returns to IDLE.
REQ-041 Timeout (macro on, TIMEOUT_CYCLES=8): waitrequest held high -> fetch_err=1 after 8 READ cycles, avm_read=0, and FSM in HALT until rst=0.
REQ-042 Async reset: rst=0 mid-READ with the clock stopped -> avm_read=0 and instr_valid=0 immediately.
